// File: rtl/bcd_display_scanner.sv
// Six-digit MM:SS:hh seven-segment scanner with frame-boundary (tear-free) commit of new BCD counts.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero minutes digits.
module bcd_display_scanner #(
  parameter int REFRESH_DIV    = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        i_rtcclk,
  input  logic        i_reset_n,
  input  logic [23:0] i_count,
  input  logic        i_count_valid,
  input  logic        i_hold,
  input  logic        i_display_enb,
  output logic [6:0]  o_seg,
  output logic        o_dp,
  output logic [5:0]  o_an,
  output logic        o_frame_done,
  output logic        o_bcd_err
);

  localparam logic [15:0] LP_TERM = 16'(REFRESH_DIV - 1);

  logic [15:0] r_presc;
  logic [2:0]  r_idx;
  logic [23:0] r_disp;
  logic [23:0] r_pend;
  logic        r_pend_vld;
  logic        r_enb_d;

  logic        w_term;
  logic        w_wrap;
  logic        w_commit;
  logic        w_cap;
  logic [3:0]  w_nib;
  logic        w_blank;
  logic [6:0]  w_seg_hi;
  logic        w_dp_hi;
  logic [5:0]  w_an_hi;

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    f_decode = 7'b1111110;
      4'd1:    f_decode = 7'b0110000;
      4'd2:    f_decode = 7'b1101101;
      4'd3:    f_decode = 7'b1111001;
      4'd4:    f_decode = 7'b0110011;
      4'd5:    f_decode = 7'b1011011;
      4'd6:    f_decode = 7'b1011111;
      4'd7:    f_decode = 7'b1110000;
      4'd8:    f_decode = 7'b1111111;
      4'd9:    f_decode = 7'b1111011;
      default: f_decode = 7'b0000001;
    endcase
  endfunction

  // The first enabled cycle after a disable acts like a frame boundary so pending data shows at once.
  assign w_term   = (r_presc == LP_TERM);
  assign w_wrap   = i_display_enb && w_term && (r_idx == 3'd5);
  assign w_commit = w_wrap || (i_display_enb && !r_enb_d);
  assign w_cap    = i_count_valid && !i_hold;

  // Select the current digit nibble and apply optional leading-zero blanking.
  always_comb begin
    w_nib   = 4'd0;
    w_blank = 1'b0;
    case (r_idx)
      3'd0:    w_nib = r_disp[3:0];
      3'd1:    w_nib = r_disp[7:4];
      3'd2:    w_nib = r_disp[11:8];
      3'd3:    w_nib = r_disp[15:12];
      3'd4:    w_nib = r_disp[19:16];
      3'd5:    w_nib = r_disp[23:20];
      default: w_nib = 4'd0;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    if (r_idx == 3'd5) begin
      w_blank = (r_disp[23:20] == 4'd0);
    end else if (r_idx == 3'd4) begin
      w_blank = (r_disp[23:16] == 8'd0);
    end else begin
      w_blank = 1'b0;
    end
`endif
  end

  // Active-high output images; anodes stay dark on prescaler count 0 to avoid ghosting.
  always_comb begin
    w_seg_hi = 7'd0;
    w_dp_hi  = 1'b0;
    w_an_hi  = 6'd0;
    if (i_display_enb) begin
      w_seg_hi = w_blank ? 7'd0 : f_decode(w_nib);
      w_dp_hi  = !w_blank && ((r_idx == 3'd4) || (r_idx == 3'd2));
      w_an_hi  = (r_presc != 16'd0) ? (6'd1 << r_idx) : 6'd0;
    end else begin
      w_seg_hi = 7'd0;
      w_dp_hi  = 1'b0;
      w_an_hi  = 6'd0;
    end
  end

  // Scan counters, capture/commit of counts, and registered pin drivers.
  always_ff @(posedge i_rtcclk) begin
    if (!i_reset_n) begin
      r_presc      <= 16'd0;
      r_idx        <= 3'd0;
      r_disp       <= 24'd0;
      r_pend       <= 24'd0;
      r_pend_vld   <= 1'b0;
      r_enb_d      <= 1'b0;
      o_seg        <= {7{SEG_ACTIVE_LOW}};
      o_dp         <= SEG_ACTIVE_LOW;
      o_an         <= {6{AN_ACTIVE_LOW}};
      o_frame_done <= 1'b0;
      o_bcd_err    <= 1'b0;
    end else begin
      r_enb_d <= i_display_enb;
      if (!i_display_enb) begin
        r_presc <= 16'd0;
        r_idx   <= 3'd0;
      end else if (w_term) begin
        r_presc <= 16'd0;
        r_idx   <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
      end else begin
        r_presc <= r_presc + 16'd1;
      end

      if (w_cap) begin
        r_pend <= i_count;
      end
      if (w_commit) begin
        if (w_cap) begin
          r_disp <= i_count;
        end else if (r_pend_vld) begin
          r_disp <= r_pend;
        end
        r_pend_vld <= 1'b0;
      end else if (w_cap) begin
        r_pend_vld <= 1'b1;
      end

      o_frame_done <= w_wrap;
      o_bcd_err    <= o_bcd_err || (i_display_enb && (w_nib > 4'd9));
      o_seg        <= w_seg_hi ^ {7{SEG_ACTIVE_LOW}};
      o_dp         <= w_dp_hi ^ SEG_ACTIVE_LOW;
      o_an         <= w_an_hi ^ {6{AN_ACTIVE_LOW}};
    end
  end

endmodule
